sr_bank_ctrl: RTL



---
 rtl/sr_bank_ctrl.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/sr_bank_ctrl.sv
// Round-robin scheduler that serialises set/clear commands onto a bank of SR cells.
// Drives a cell for one clock, reads back its q1 and acknowledges with gnt/err.
module sr_bank_ctrl #(
    parameter int NREQ  = 4,
    parameter int NCELL = 8,
    parameter int IW    = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      op,
    input  logic [NREQ*IW-1:0]   idx,
    input  logic [NCELL-1:0]     q_fb,
    output logic [NCELL-1:0]     sr_a,
    output logic [NCELL-1:0]     sr_b,
    output logic [NREQ-1:0]      gnt,
    output logic                 err,
    output logic                 busy
);

    // state  | meaning
    // IDLE   | arbitrate among req, latch winner's op/idx, advance ptr
    // DRIVE  | one-cycle a/b pulse on the selected cell
    // SETTLE | bank held (a=b=0), compare q_fb[idx] against op
    // DONE   | gnt[winner] high, err qualifies it

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [IW:0] NCELL_W = (IW+1)'(NCELL);

    typedef enum logic [1:0] {IDLE, DRIVE, SETTLE, DONE} state_t;

    state_t          state;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   win_l;
    logic            op_l;
    logic [IW-1:0]   idx_l;

    logic            win_found;
    logic [PW-1:0]   win_c;
    logic [PW-1:0]   ptr_nx;
    logic            op_c;
    logic [IW-1:0]   idx_c;
    logic            idx_bad;
    logic [NCELL-1:0] cell_dec_c;
    logic [NCELL-1:0] cell_sel_l;
    logic [NREQ-1:0] win_oh_c;
    logic [NREQ-1:0] win_oh_l;
    logic            q_sel;

    // First requester at or after ptr, wrapping modulo NREQ.
    always_comb begin
        win_found = 1'b0;
        win_c     = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!win_found && req[(int'(ptr) + i) % NREQ]) begin
                win_found = 1'b1;
                win_c     = PW'((int'(ptr) + i) % NREQ);
            end
        end
    end

    always_comb begin
        op_c    = op[win_c];
        idx_c   = idx[int'(win_c)*IW +: IW];
        idx_bad = ({1'b0, idx_c} >= NCELL_W);
        ptr_nx  = (win_c == PW'(NREQ-1)) ? '0 : win_c + PW'(1);
    end

    always_comb begin
        cell_dec_c = '0;
        cell_sel_l = '0;
        for (int c = 0; c < NCELL; c++) begin
            cell_dec_c[c] = (idx_c == IW'(c));
            cell_sel_l[c] = (idx_l == IW'(c));
        end
    end

    always_comb begin
        win_oh_c = '0;
        win_oh_l = '0;
        for (int r = 0; r < NREQ; r++) begin
            win_oh_c[r] = (win_c == PW'(r));
            win_oh_l[r] = (win_l == PW'(r));
        end
    end

    assign q_sel = |(q_fb & cell_sel_l);

    // sr_a and sr_b are always loaded from complementary masks of one decode,
    // so a=b=1 cannot be produced on any cell.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= '0;
            win_l <= '0;
            op_l  <= 1'b0;
            idx_l <= '0;
            sr_a  <= '0;
            sr_b  <= '0;
            gnt   <= '0;
            err   <= 1'b0;
            busy  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    sr_a <= '0;
                    sr_b <= '0;
                    gnt  <= '0;
                    err  <= 1'b0;
                    if (win_found) begin
                        win_l <= win_c;
                        op_l  <= op_c;
                        idx_l <= idx_c;
                        ptr   <= ptr_nx;
                        busy  <= 1'b1;
                        if (idx_bad) begin
                            state <= DONE;
                            gnt   <= win_oh_c;
                            err   <= 1'b1;
                        end else begin
                            state <= DRIVE;
                            sr_a  <= op_c ? cell_dec_c : '0;
                            sr_b  <= op_c ? '0 : cell_dec_c;
                        end
                    end else begin
                        busy <= 1'b0;
                    end
                end
                DRIVE: begin
                    sr_a  <= '0;
                    sr_b  <= '0;
                    state <= SETTLE;
                end
                SETTLE: begin
                    err   <= (q_sel != op_l);
                    gnt   <= win_oh_l;
                    state <= DONE;
                end
                DONE: begin
                    gnt   <= '0;
                    err   <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    sr_a  <= '0;
                    sr_b  <= '0;
                    gnt   <= '0;
                    err   <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
